wb_regfile_2way: RTL and testbench

Writeback stage and architectural register file for the 2-way superscalar MIPS core. It consumes the outputs of both lanes' MEM/WB pipeline registers and selects each lane's writeback value (load data, ALU result or JAL link address). It commits up to two register writes per cycle and serves four combinational read ports to decode. Same-cycle writes bypass into the read ports, and the block keeps a retired-instruction counter.

---
 rtl/wb_regfile_2way.sv | 92 +++++++++
 tb/tb_wb_regfile_2way.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_regfile_2way.sv
// Writeback select and 32x32 architectural register file for the 2-way core.
// Two commits per cycle (lane 1 wins conflicts), four bypassed read ports, retire counter.
module wb_regfile_2way #(
  parameter logic [31:0] JAL_OFFSET = 32'd4,
  parameter int          CNT_W      = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [31:0]      WB_inst0,
  input  logic [31:0]      WB_inst1,
  input  logic             RegWrite_WB0,
  input  logic             RegWrite_WB1,
  input  logic             MemtoReg_WB0,
  input  logic             MemtoReg_WB1,
  input  logic             JAL_WB0,
  input  logic             JAL_WB1,
  input  logic [4:0]       WriteReg_WB0,
  input  logic [4:0]       WriteReg_WB1,
  input  logic [31:0]      readData0,
  input  logic [31:0]      readData1,
  input  logic [31:0]      aluResult_WB0,
  input  logic [31:0]      aluResult_WB1,
  input  logic [31:0]      WB_PC0,
  input  logic [31:0]      WB_PC1,
  input  logic [4:0]       rs0,
  input  logic [4:0]       rt0,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rt1,
  output logic [31:0]      rs0_data,
  output logic [31:0]      rt0_data,
  output logic [31:0]      rs1_data,
  output logic [31:0]      rt1_data,
  output logic             wb_en0,
  output logic             wb_en1,
  output logic [4:0]       wb_reg0,
  output logic [4:0]       wb_reg1,
  output logic [31:0]      wb_data0,
  output logic [31:0]      wb_data1,
  output logic [CNT_W-1:0] retired_count
);

  logic [31:0]      regs [32];
  logic             keep0;
  logic [CNT_W-1:0] inc0, inc1;

  always_comb begin
    wb_data0 = aluResult_WB0;
    if (JAL_WB0)           wb_data0 = WB_PC0 + JAL_OFFSET;
    else if (MemtoReg_WB0) wb_data0 = readData0;
    wb_data1 = aluResult_WB1;
    if (JAL_WB1)           wb_data1 = WB_PC1 + JAL_OFFSET;
    else if (MemtoReg_WB1) wb_data1 = readData1;
  end

  assign wb_en0  = RegWrite_WB0 & (WriteReg_WB0 != 5'd0) & ~Reset;
  assign wb_en1  = RegWrite_WB1 & (WriteReg_WB1 != 5'd0) & ~Reset;
  assign wb_reg0 = WriteReg_WB0;
  assign wb_reg1 = WriteReg_WB1;

  // Lane 1 is younger, so lane 0's write to the same register is dropped.
  assign keep0 = wb_en0 & ~(wb_en1 & (wb_reg1 == wb_reg0));

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      if (keep0)  regs[wb_reg0] <= wb_data0;
      if (wb_en1) regs[wb_reg1] <= wb_data1;
    end
  end

  assign inc0 = CNT_W'(WB_inst0 != 32'd0);
  assign inc1 = CNT_W'(WB_inst1 != 32'd0);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) retired_count <= '0;
    else       retired_count <= retired_count + inc0 + inc1;
  end

  function automatic logic [31:0] rd_port(input logic [4:0] a);
    if (a == 5'd0)                   return 32'd0;
    else if (wb_en1 && wb_reg1 == a) return wb_data1;
    else if (wb_en0 && wb_reg0 == a) return wb_data0;
    else                             return regs[a];
  endfunction

  assign rs0_data = rd_port(rs0);
  assign rt0_data = rd_port(rt0);
  assign rs1_data = rd_port(rs1);
  assign rt1_data = rd_port(rt1);

endmodule

// File: tb/tb_wb_regfile_2way.sv
// Randomized bench for wb_regfile_2way against an architectural-state model.
// A second instance with a 2-bit counter exercises counter wraparound.
module tb_wb_regfile_2way;

  logic        clk, Reset;
  logic [31:0] WB_inst0, WB_inst1;
  logic        RegWrite_WB0, RegWrite_WB1, MemtoReg_WB0, MemtoReg_WB1, JAL_WB0, JAL_WB1;
  logic [4:0]  WriteReg_WB0, WriteReg_WB1;
  logic [31:0] readData0, readData1, aluResult_WB0, aluResult_WB1, WB_PC0, WB_PC1;
  logic [4:0]  rs0, rt0, rs1, rt1;

  logic [31:0] rs0_data, rt0_data, rs1_data, rt1_data, wb_data0, wb_data1;
  logic        wb_en0, wb_en1;
  logic [4:0]  wb_reg0, wb_reg1;
  logic [31:0] retired_count;

  logic [31:0] s_rs0, s_rt0, s_rs1, s_rt1, s_d0, s_d1;
  logic        s_en0, s_en1;
  logic [4:0]  s_r0, s_r1;
  logic [1:0]  s_cnt;

  int errors = 0;
  int checks = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  wb_regfile_2way dut (
    .clk(clk), .Reset(Reset), .WB_inst0(WB_inst0), .WB_inst1(WB_inst1),
    .RegWrite_WB0(RegWrite_WB0), .RegWrite_WB1(RegWrite_WB1),
    .MemtoReg_WB0(MemtoReg_WB0), .MemtoReg_WB1(MemtoReg_WB1),
    .JAL_WB0(JAL_WB0), .JAL_WB1(JAL_WB1),
    .WriteReg_WB0(WriteReg_WB0), .WriteReg_WB1(WriteReg_WB1),
    .readData0(readData0), .readData1(readData1),
    .aluResult_WB0(aluResult_WB0), .aluResult_WB1(aluResult_WB1),
    .WB_PC0(WB_PC0), .WB_PC1(WB_PC1),
    .rs0(rs0), .rt0(rt0), .rs1(rs1), .rt1(rt1),
    .rs0_data(rs0_data), .rt0_data(rt0_data), .rs1_data(rs1_data), .rt1_data(rt1_data),
    .wb_en0(wb_en0), .wb_en1(wb_en1), .wb_reg0(wb_reg0), .wb_reg1(wb_reg1),
    .wb_data0(wb_data0), .wb_data1(wb_data1), .retired_count(retired_count)
  );

  wb_regfile_2way #(.CNT_W(2)) dut_w (
    .clk(clk), .Reset(Reset), .WB_inst0(WB_inst0), .WB_inst1(WB_inst1),
    .RegWrite_WB0(RegWrite_WB0), .RegWrite_WB1(RegWrite_WB1),
    .MemtoReg_WB0(MemtoReg_WB0), .MemtoReg_WB1(MemtoReg_WB1),
    .JAL_WB0(JAL_WB0), .JAL_WB1(JAL_WB1),
    .WriteReg_WB0(WriteReg_WB0), .WriteReg_WB1(WriteReg_WB1),
    .readData0(readData0), .readData1(readData1),
    .aluResult_WB0(aluResult_WB0), .aluResult_WB1(aluResult_WB1),
    .WB_PC0(WB_PC0), .WB_PC1(WB_PC1),
    .rs0(rs0), .rt0(rt0), .rs1(rs1), .rt1(rt1),
    .rs0_data(s_rs0), .rt0_data(s_rt0), .rs1_data(s_rs1), .rt1_data(s_rt1),
    .wb_en0(s_en0), .wb_en1(s_en1), .wb_reg0(s_r0), .wb_reg1(s_r1),
    .wb_data0(s_d0), .wb_data1(s_d1), .retired_count(s_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_cnt = 32'd0;
  endtask

  function automatic logic [31:0] lane_val(input logic jal, input logic mem,
                                          input logic [31:0] pc, input logic [31:0] ld,
                                          input logic [31:0] alu);
    if (jal)      return pc + 32'd4;
    else if (mem) return ld;
    else          return alu;
  endfunction

  // Architectural view: a same-cycle read sees the register file as it will be
  // after this cycle's commits, applied in program order (lane 0 then lane 1).
  task automatic step(input string tag);
    logic [31:0] d0, d1;
    logic        e0, e1;
    logic [31:0] nxt [32];
    #1;
    d0 = lane_val(JAL_WB0, MemtoReg_WB0, WB_PC0, readData0, aluResult_WB0);
    d1 = lane_val(JAL_WB1, MemtoReg_WB1, WB_PC1, readData1, aluResult_WB1);
    e0 = RegWrite_WB0 && (WriteReg_WB0 != 5'd0) && !Reset;
    e1 = RegWrite_WB1 && (WriteReg_WB1 != 5'd0) && !Reset;
    nxt = m_regs;
    if (e0) nxt[WriteReg_WB0] = d0;
    if (e1) nxt[WriteReg_WB1] = d1;
    nxt[0] = 32'd0;
    chk({tag, "_en0"},  64'(wb_en0),   64'(e0));
    chk({tag, "_en1"},  64'(wb_en1),   64'(e1));
    chk({tag, "_reg0"}, 64'(wb_reg0),  64'(WriteReg_WB0));
    chk({tag, "_reg1"}, 64'(wb_reg1),  64'(WriteReg_WB1));
    chk({tag, "_dat0"}, 64'(wb_data0), 64'(d0));
    chk({tag, "_dat1"}, 64'(wb_data1), 64'(d1));
    chk({tag, "_rs0"},  64'(rs0_data), 64'(nxt[rs0]));
    chk({tag, "_rt0"},  64'(rt0_data), 64'(nxt[rt0]));
    chk({tag, "_rs1"},  64'(rs1_data), 64'(nxt[rs1]));
    chk({tag, "_rt1"},  64'(rt1_data), 64'(nxt[rt1]));
    chk({tag, "_cnt"},  64'(retired_count), 64'(m_cnt));
    chk({tag, "_w_ctl"}, {s_en1, s_en0, s_r1, s_r0}, {e1, e0, WriteReg_WB1, WriteReg_WB0});
    chk({tag, "_w_dat"}, {s_d1, s_d0}, {d1, d0});
    chk({tag, "_w_rd0"}, {s_rs0, s_rt0}, {nxt[rs0], nxt[rt0]});
    chk({tag, "_w_rd1"}, {s_rs1, s_rt1}, {nxt[rs1], nxt[rt1]});
    chk({tag, "_w_cnt"}, 64'(s_cnt), 64'(m_cnt[1:0]));
    @(posedge clk);
    if (!Reset) begin
      m_regs = nxt;
      m_cnt  = m_cnt + 32'(WB_inst0 != 32'd0) + 32'(WB_inst1 != 32'd0);
    end
    #1;
  endtask

  task automatic idle_inputs();
    WB_inst0 = 0; WB_inst1 = 0;
    RegWrite_WB0 = 0; RegWrite_WB1 = 0; MemtoReg_WB0 = 0; MemtoReg_WB1 = 0;
    JAL_WB0 = 0; JAL_WB1 = 0; WriteReg_WB0 = 0; WriteReg_WB1 = 0;
    readData0 = 0; readData1 = 0; aluResult_WB0 = 0; aluResult_WB1 = 0;
    WB_PC0 = 0; WB_PC1 = 0;
  endtask

  initial begin
    Reset = 1'b1;
    idle_inputs();
    rs0 = 0; rt0 = 0; rs1 = 0; rt1 = 0;
    clear_model();
    @(posedge clk); #1;
    step("rst_hold");
    Reset = 1'b0;

    // Retire counter: (1,1),(1,0),(0,0),(1,1)
    WB_inst0 = 32'h1; WB_inst1 = 32'h2;  step("cnt_a"); chk("cnt_after_11", 64'(retired_count), 64'd2);
    WB_inst1 = 32'h0;                    step("cnt_b"); chk("cnt_after_10", 64'(retired_count), 64'd3);
    WB_inst0 = 32'h0;                    step("cnt_c"); chk("cnt_after_00", 64'(retired_count), 64'd3);
    WB_inst0 = 32'h5; WB_inst1 = 32'h7;  step("cnt_d"); chk("cnt_wrap2", 64'(s_cnt), 64'd1);

    // Dual commit with same-cycle bypass
    idle_inputs();
    RegWrite_WB0 = 1; WriteReg_WB0 = 5;  aluResult_WB0 = 32'h1234_5678;
    RegWrite_WB1 = 1; WriteReg_WB1 = 6;  MemtoReg_WB1 = 1; readData1 = 32'hDEAD_BEEF;
    aluResult_WB1 = 32'h0BAD_0BAD;
    rs0 = 5; rt0 = 6;
    #1;
    chk("dual_byp_rs0", 64'(rs0_data), 64'h1234_5678);
    chk("dual_byp_rt0", 64'(rt0_data), 64'hDEAD_BEEF);
    step("dual");
    idle_inputs();
    #1;
    chk("dual_arr_rs0", 64'(rs0_data), 64'h1234_5678);
    chk("dual_arr_rt0", 64'(rt0_data), 64'hDEAD_BEEF);
    step("dual_post");

    // Write-write conflict on $9
    RegWrite_WB0 = 1; WriteReg_WB0 = 9; aluResult_WB0 = 32'd1;
    RegWrite_WB1 = 1; WriteReg_WB1 = 9; aluResult_WB1 = 32'd2;
    rs1 = 9;
    #1;
    chk("ww_byp", 64'(rs1_data), 64'd2);
    step("ww");
    idle_inputs();
    #1;
    chk("ww_arr", 64'(rs1_data), 64'd2);

    // JAL link into $31, then a write to $0
    RegWrite_WB1 = 1; JAL_WB1 = 1; WB_PC1 = 32'h0040_0010; WriteReg_WB1 = 31;
    aluResult_WB1 = 32'h5555_5555; rt1 = 31;
    step("jal");
    idle_inputs();
    #1;
    chk("jal_arr", 64'(rt1_data), 64'h0040_0014);
    RegWrite_WB0 = 1; WriteReg_WB0 = 0; aluResult_WB0 = 32'hFFFF_FFFF; rs0 = 0;
    #1;
    chk("r0_en", 64'(wb_en0), 64'd0);
    chk("r0_rd", 64'(rs0_data), 64'd0);
    step("r0");

    // Asynchronous reset mid-cycle with live contents and pending writes
    idle_inputs();
    RegWrite_WB0 = 1; WriteReg_WB0 = 5; aluResult_WB0 = 32'hABCD_0001; WB_inst0 = 32'h1;
    rs0 = 5; rt0 = 6; rs1 = 9; rt1 = 31;
    #2;
    Reset = 1'b1;
    clear_model();
    #1;
    chk("arst_rs0", 64'(rs0_data), 64'd0);
    chk("arst_rt0", 64'(rt0_data), 64'd0);
    chk("arst_rs1", 64'(rs1_data), 64'd0);
    chk("arst_rt1", 64'(rt1_data), 64'd0);
    chk("arst_cnt", 64'(retired_count), 64'd0);
    chk("arst_dat", 64'(wb_data0), 64'hABCD_0001);
    step("arst_hold");
    Reset = 1'b0;
    step("arst_rel");

    // Randomized traffic with occasional mid-cycle resets
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0) begin
        Reset = 1'b1;
        clear_model();
      end else begin
        Reset = 1'b0;
      end
      WB_inst0      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      WB_inst1      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      RegWrite_WB0  = 1'($urandom);
      RegWrite_WB1  = 1'($urandom);
      MemtoReg_WB0  = 1'($urandom);
      MemtoReg_WB1  = 1'($urandom);
      JAL_WB0       = ($urandom_range(0, 4) == 0);
      JAL_WB1       = ($urandom_range(0, 4) == 0);
      WriteReg_WB0  = 5'($urandom_range(0, 7));
      WriteReg_WB1  = 5'($urandom_range(0, 7));
      readData0     = $urandom;
      readData1     = $urandom;
      aluResult_WB0 = $urandom;
      aluResult_WB1 = $urandom;
      WB_PC0        = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
      WB_PC1        = $urandom;
      rs0 = 5'($urandom_range(0, 7));
      rt0 = 5'($urandom_range(0, 7));
      rs1 = 5'($urandom);
      rt1 = 5'($urandom_range(0, 7));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
